// File: rtl/pkt_sched_pkg.sv
// rtl/pkt_sched_pkg.sv - shared constants and helpers for the packet scheduler slice
// Contents:
//   DEF_NUM_FIFO / DEF_PKT_LEN_WIDTH / DEF_LEN_DEPTH  default queue geometry
//   MAX_KEEP_WIDTH  widest tkeep the popcount helper accepts (zero-extend narrower)
//   pkt_len_t       packet length in bytes
//   popcount_keep   number of enabled bytes in a beat
//   sat_add         length add that sticks at all-ones instead of wrapping
package pkt_sched_pkg;

  localparam int DEF_NUM_FIFO      = 3;
  localparam int DEF_PKT_LEN_WIDTH = 16;
  localparam int DEF_LEN_DEPTH     = 16;
  localparam int MAX_KEEP_WIDTH    = 64;

  typedef logic [DEF_PKT_LEN_WIDTH-1:0] pkt_len_t;

  function automatic pkt_len_t popcount_keep(input logic [MAX_KEEP_WIDTH-1:0] keep);
    pkt_len_t n;
    n = '0;
    for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
      n = n + pkt_len_t'(keep[i]);
    end
    return n;
  endfunction

  function automatic pkt_len_t sat_add(input pkt_len_t a, input pkt_len_t b);
    logic [DEF_PKT_LEN_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DEF_PKT_LEN_WIDTH] ? '1 : s[DEF_PKT_LEN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pkt_len_fifo.sv
// rtl/pkt_len_fifo.sv - per-queue circular FIFO of completed packet lengths
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push, push_len       enqueue one packet length
//   pop                  dequeue the head entry
//   head_len             registered head length, 0 when empty
//   head_valid           at least one entry held
//   full                 count == LEN_DEPTH
//   overflow, underflow  single-cycle pulses: push dropped / pop on empty
module pkt_len_fifo
  import pkt_sched_pkg::*;
#(
  parameter int PKT_LEN_WIDTH = DEF_PKT_LEN_WIDTH,
  parameter int LEN_DEPTH     = DEF_LEN_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [PKT_LEN_WIDTH-1:0] push_len,
  input  logic                     pop,
  output logic [PKT_LEN_WIDTH-1:0] head_len,
  output logic                     head_valid,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(LEN_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LEN_DEPTH);

  logic [PKT_LEN_WIDTH-1:0] mem [LEN_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count, count_next;
  logic [PKT_LEN_WIDTH-1:0] head_q, head_next;
  logic                     empty, do_push, do_pop;

  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign do_push   = push && ((count != DEPTH_C) || do_pop);
  assign overflow  = push && !do_push;
  assign underflow = pop && empty;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Head is kept in a register so the scheduler sees a clean flop output.
  // The only case that bypasses memory is when the entry being written is
  // about to become the head (FIFO empty, or draining its last entry).
  always_comb begin
    head_next = head_q;
    if (count_next == '0) begin
      head_next = '0;
    end else if (do_pop) begin
      head_next = (count == CNT_W'(1)) ? push_len : mem[rd_ptr + PTR_W'(1)];
    end else if (empty) begin
      head_next = push_len;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count_next;
      head_q <= head_next;
    end
  end

  assign head_len   = head_q;
  assign head_valid = !empty;
  assign full       = (count == DEPTH_C);

endmodule

// File: rtl/pkt_len_tracker.sv
// rtl/pkt_len_tracker.sv - byte-counts ingress packets and exposes per-queue head lengths
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   in_tvalid/in_tready/in_tkeep/
//   in_tlast/in_tdest                  snooped ingress beat
//   in_len_ready                       target queue's length FIFO has room
//   out_sel/out_tvalid/out_tready/
//   out_tlast                          egress beat; tlast pops queue out_sel
//   fifo_packet_length                 head length of queue i at [i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH]
//   fifo_tvalid                        queue i holds a complete packet
//   len_full                           length FIFO i is full
//   err_overflow, err_underflow        sticky error flags
// Lengths are computed with the package helpers, so PKT_LEN_WIDTH is
// expected to stay at DEF_PKT_LEN_WIDTH.
module pkt_len_tracker
  import pkt_sched_pkg::*;
#(
  parameter int NUM_FIFO      = DEF_NUM_FIFO,
  parameter int PKT_LEN_WIDTH = DEF_PKT_LEN_WIDTH,
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int LEN_DEPTH     = DEF_LEN_DEPTH,
  parameter int SEL_WIDTH     = $clog2(NUM_FIFO)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_tvalid,
  input  logic                              in_tready,
  input  logic [KEEP_WIDTH-1:0]             in_tkeep,
  input  logic                              in_tlast,
  input  logic [SEL_WIDTH-1:0]              in_tdest,
  output logic                              in_len_ready,
  input  logic [SEL_WIDTH-1:0]              out_sel,
  input  logic                              out_tvalid,
  input  logic                              out_tready,
  input  logic                              out_tlast,
  output logic [NUM_FIFO*PKT_LEN_WIDTH-1:0] fifo_packet_length,
  output logic [NUM_FIFO-1:0]               fifo_tvalid,
  output logic [NUM_FIFO-1:0]               len_full,
  output logic                              err_overflow,
  output logic                              err_underflow
);

  localparam int SEL_SPAN = 1 << SEL_WIDTH;

  logic [PKT_LEN_WIDTH-1:0]  accum;
  logic                      in_pkt;
  logic [SEL_WIDTH-1:0]      cur_dest;
  logic [SEL_WIDTH-1:0]      dest;
  logic [MAX_KEEP_WIDTH-1:0] keep_ext;
  logic [PKT_LEN_WIDTH-1:0]  beat_bytes, pkt_total;
  logic                      beat_take, push, pop;
  logic [SEL_SPAN-1:0]       full_pad, exists_pad;
  logic                      bad_dest_push;
  logic [NUM_FIFO-1:0]       q_push, q_pop, q_ovf, q_unf;

  always_comb begin
    keep_ext = '0;
    keep_ext[KEEP_WIDTH-1:0] = in_tkeep;
  end

  assign beat_bytes = PKT_LEN_WIDTH'(popcount_keep(keep_ext));
  assign pkt_total  = PKT_LEN_WIDTH'(sat_add(pkt_len_t'(accum), pkt_len_t'(beat_bytes)));

  // tdest only matters on the first beat; later beats follow the latched queue.
  assign dest = in_pkt ? cur_dest : in_tdest;

  // Unused select codes look like permanently full queues: never ready, and a
  // forced push there is dropped as an overflow.
  always_comb begin
    full_pad   = '1;
    exists_pad = '0;
    full_pad[NUM_FIFO-1:0]   = len_full;
    exists_pad[NUM_FIFO-1:0] = '1;
  end

  assign in_len_ready  = !full_pad[dest];
  assign beat_take     = in_tvalid && in_tready;
  assign push          = beat_take && in_tlast;
  assign pop           = out_tvalid && out_tready && out_tlast;
  assign bad_dest_push = push && !exists_pad[dest];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accum    <= '0;
      in_pkt   <= 1'b0;
      cur_dest <= '0;
    end else if (beat_take) begin
      if (in_tlast) begin
        accum  <= '0;
        in_pkt <= 1'b0;
      end else begin
        accum  <= pkt_total;
        in_pkt <= 1'b1;
        if (!in_pkt) cur_dest <= in_tdest;
      end
    end
  end

  for (genvar i = 0; i < NUM_FIFO; i++) begin : g_q
    assign q_push[i] = push && (dest == SEL_WIDTH'(i));
    assign q_pop[i]  = pop && (out_sel == SEL_WIDTH'(i));

    pkt_len_fifo #(
      .PKT_LEN_WIDTH (PKT_LEN_WIDTH),
      .LEN_DEPTH     (LEN_DEPTH)
    ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (q_push[i]),
      .push_len   (pkt_total),
      .pop        (q_pop[i]),
      .head_len   (fifo_packet_length[i*PKT_LEN_WIDTH +: PKT_LEN_WIDTH]),
      .head_valid (fifo_tvalid[i]),
      .full       (len_full[i]),
      .overflow   (q_ovf[i]),
      .underflow  (q_unf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if ((|q_ovf) || bad_dest_push) err_overflow <= 1'b1;
      if (|q_unf) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pkt_len_tracker.sv
// tb/tb_pkt_len_tracker.sv - self-checking bench for pkt_len_tracker
module tb_pkt_len_tracker;

  localparam int NQ    = 3;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_tvalid, in_tready, in_tlast;
  logic [7:0]  in_tkeep;
  logic [1:0]  in_tdest;
  logic        in_len_ready;
  logic [1:0]  out_sel;
  logic        out_tvalid, out_tready, out_tlast;
  logic [47:0] fifo_packet_length;
  logic [2:0]  fifo_tvalid, len_full;
  logic        err_overflow, err_underflow;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue of lengths per destination plus packet accumulator.
  int mq[NQ][$];
  int m_acc;
  bit m_in_pkt;
  int m_dest;
  bit m_of, m_uf;

  pkt_len_tracker dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_tvalid          (in_tvalid),
    .in_tready          (in_tready),
    .in_tkeep           (in_tkeep),
    .in_tlast           (in_tlast),
    .in_tdest           (in_tdest),
    .in_len_ready       (in_len_ready),
    .out_sel            (out_sel),
    .out_tvalid         (out_tvalid),
    .out_tready         (out_tready),
    .out_tlast          (out_tlast),
    .fifo_packet_length (fifo_packet_length),
    .fifo_tvalid        (fifo_tvalid),
    .len_full           (len_full),
    .err_overflow       (err_overflow),
    .err_underflow      (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) mq[i].delete();
    m_acc = 0; m_in_pkt = 0; m_dest = 0; m_of = 0; m_uf = 0;
  endtask

  // Applies the spec rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit do_push;
    int push_d, push_len, tot, q;
    do_push = 0; push_d = 0; push_len = 0;
    if (in_tvalid && in_tready) begin
      tot = m_acc + $countones(in_tkeep);
      if (tot > 65535) tot = 65535;
      if (in_tlast) begin
        do_push  = 1;
        push_d   = m_in_pkt ? m_dest : int'(in_tdest);
        push_len = tot;
        m_acc = 0; m_in_pkt = 0;
      end else begin
        if (!m_in_pkt) m_dest = int'(in_tdest);
        m_acc = tot; m_in_pkt = 1;
      end
    end
    if (out_tvalid && out_tready && out_tlast && int'(out_sel) < NQ) begin
      q = int'(out_sel);
      if (mq[q].size() == 0) m_uf = 1;
      else void'(mq[q].pop_front());
    end
    if (do_push) begin
      if (push_d >= NQ || mq[push_d].size() >= DEPTH) m_of = 1;
      else mq[push_d].push_back(push_len);
    end
  endtask

  function automatic logic [2:0] exp_valid();
    logic [2:0] v;
    v = '0;
    for (int i = 0; i < NQ; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  function automatic logic [2:0] exp_full();
    logic [2:0] v;
    v = '0;
    for (int i = 0; i < NQ; i++) v[i] = (mq[i].size() == DEPTH);
    return v;
  endfunction

  function automatic logic [47:0] exp_len();
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < NQ; i++)
      if (mq[i].size() != 0) v[i*16 +: 16] = 16'(mq[i][0]);
    return v;
  endfunction

  function automatic logic [7:0] rand_keep(input int n);
    logic [7:0] k;
    int placed, b;
    k = '0; placed = 0;
    while (placed < n) begin
      b = $urandom_range(7);
      if (!k[b]) begin k[b] = 1'b1; placed++; end
    end
    return k;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] d, input logic [7:0] k, input logic l);
    in_tvalid = 1'b1; in_tready = 1'b1; in_tdest = d; in_tkeep = k; in_tlast = l;
    tick();
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] d, input int n);
    int rem, k;
    rem = n;
    while (rem > 0) begin
      k = (rem > 8) ? 8 : rem;
      rem -= k;
      beat(d, rand_keep(k), rem == 0);
    end
  endtask

  task automatic pop_q(input logic [1:0] s);
    out_sel = s; out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = 1'b1;
    tick();
    out_tvalid = 1'b0; out_tlast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    model_reset();
    checks++; if (fifo_tvalid !== 3'b000) begin failures++; $display("FAIL reset_tvalid got=%b exp=000", fifo_tvalid); end
    checks++; if (fifo_packet_length !== 48'h0) begin failures++; $display("FAIL reset_len got=%h exp=0", fifo_packet_length); end
    checks++; if (len_full !== 3'b000) begin failures++; $display("FAIL reset_full got=%b exp=000", len_full); end
    checks++; if ({err_overflow, err_underflow} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", {err_overflow, err_underflow}); end
    checks++; if (in_len_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_len_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_multi_beat();
    beat(2'd1, 8'hFF, 1'b0);
    beat(2'd1, 8'hFF, 1'b0);
    checks++; if (fifo_tvalid !== 3'b000) begin failures++; $display("FAIL partial_tvalid got=%b exp=000", fifo_tvalid); end
    beat(2'd1, 8'h0F, 1'b1);
    checks++; if (fifo_tvalid !== 3'b010) begin failures++; $display("FAIL mb_tvalid got=%b exp=010", fifo_tvalid); end
    checks++; if (fifo_packet_length[31:16] !== 16'd20) begin failures++; $display("FAIL mb_len got=%0d exp=20", fifo_packet_length[31:16]); end
    checks++; if (fifo_packet_length !== exp_len()) begin failures++; $display("FAIL mb_len_model got=%h exp=%h", fifo_packet_length, exp_len()); end
    pop_q(2'd1);
    checks++; if (fifo_tvalid[1] !== 1'b0) begin failures++; $display("FAIL mb_pop_tvalid got=%b exp=0", fifo_tvalid[1]); end
    checks++; if (fifo_packet_length[31:16] !== 16'd0) begin failures++; $display("FAIL mb_pop_len got=%0d exp=0", fifo_packet_length[31:16]); end
  endtask

  task automatic test_tdest_switch();
    beat(2'd2, 8'h01, 1'b1);
    checks++; if (fifo_packet_length[47:32] !== 16'd1 || fifo_tvalid[2] !== 1'b1) begin failures++; $display("FAIL single_beat got len=%0d v=%b exp len=1 v=1", fifo_packet_length[47:32], fifo_tvalid[2]); end
    beat(2'd2, 8'hFF, 1'b0);
    beat(2'd0, 8'hFF, 1'b1);
    checks++; if (fifo_tvalid !== 3'b100) begin failures++; $display("FAIL switch_tvalid got=%b exp=100", fifo_tvalid); end
    checks++; if (fifo_packet_length[47:32] !== 16'd1) begin failures++; $display("FAIL switch_head got=%0d exp=1", fifo_packet_length[47:32]); end
    pop_q(2'd2);
    checks++; if (fifo_packet_length[47:32] !== 16'd16) begin failures++; $display("FAIL switch_second got=%0d exp=16", fifo_packet_length[47:32]); end
    pop_q(2'd2);
    checks++; if (fifo_tvalid !== exp_valid() || fifo_tvalid !== 3'b000) begin failures++; $display("FAIL switch_drain got=%b exp=000", fifo_tvalid); end
  endtask

  task automatic test_underflow();
    pop_q(2'd2);
    checks++; if (err_underflow !== 1'b1) begin failures++; $display("FAIL underflow_flag got=%b exp=1", err_underflow); end
    checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL underflow_ovf got=%b exp=0", err_overflow); end
    checks++; if (fifo_tvalid !== exp_valid() || fifo_packet_length !== exp_len()) begin failures++; $display("FAIL underflow_state got v=%b l=%h exp v=%b l=%h", fifo_tvalid, fifo_packet_length, exp_valid(), exp_len()); end
  endtask

  task automatic test_fill_overflow();
    for (int n = 1; n <= DEPTH; n++) send_pkt(2'd0, n);
    checks++; if (len_full !== 3'b001) begin failures++; $display("FAIL fill_full got=%b exp=001", len_full); end
    in_tdest = 2'd0;
    #1;
    checks++; if (in_len_ready !== 1'b0) begin failures++; $display("FAIL fill_ready got=%b exp=0", in_len_ready); end
    send_pkt(2'd0, 5);
    checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf got=%b exp=1", err_overflow); end
    checks++; if (len_full !== 3'b001) begin failures++; $display("FAIL fill_full_after got=%b exp=001", len_full); end
    for (int n = 1; n <= DEPTH; n++) begin
      checks++; if (fifo_packet_length[15:0] !== 16'(n) || fifo_packet_length !== exp_len()) begin failures++; $display("FAIL fill_order[%0d] got=%0d exp=%0d", n, fifo_packet_length[15:0], n); end
      pop_q(2'd0);
    end
    checks++; if (fifo_tvalid[0] !== 1'b0 || len_full !== 3'b000) begin failures++; $display("FAIL fill_drain got v=%b f=%b exp v=0 f=000", fifo_tvalid[0], len_full); end
  endtask

  task automatic test_back_to_back();
    send_pkt(2'd0, 64);
    checks++; if (fifo_packet_length[15:0] !== 16'd64) begin failures++; $display("FAIL b2b_first got=%0d exp=64", fifo_packet_length[15:0]); end
    for (int i = 0; i < 4; i++) beat(2'd0, 8'hFF, 1'b0);
    out_sel = 2'd0; out_tvalid = 1'b1; out_tready = 1'b1; out_tlast = 1'b1;
    beat(2'd0, 8'hFF, 1'b1);
    out_tvalid = 1'b0; out_tlast = 1'b0;
    checks++; if (fifo_tvalid[0] !== 1'b1) begin failures++; $display("FAIL b2b_tvalid got=%b exp=1", fifo_tvalid[0]); end
    checks++; if (fifo_packet_length[15:0] !== 16'd40 || fifo_packet_length !== exp_len()) begin failures++; $display("FAIL b2b_head got=%0d exp=40", fifo_packet_length[15:0]); end
    pop_q(2'd0);
  endtask

  task automatic test_reset_mid_packet();
    send_pkt(2'd1, 12);
    beat(2'd0, 8'hFF, 1'b0);
    beat(2'd0, 8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (fifo_tvalid !== 3'b000 || fifo_packet_length !== 48'h0) begin failures++; $display("FAIL midrst_out got v=%b l=%h exp 0", fifo_tvalid, fifo_packet_length); end
    checks++; if ({err_overflow, err_underflow} !== 2'b00) begin failures++; $display("FAIL midrst_err got=%b exp=00", {err_overflow, err_underflow}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat(2'd0, 8'hFF, 1'b1);
    checks++; if (fifo_packet_length[15:0] !== 16'd8 || fifo_tvalid !== 3'b001) begin failures++; $display("FAIL midrst_len got=%0d v=%b exp=8 v=001", fifo_packet_length[15:0], fifo_tvalid); end
    pop_q(2'd0);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      in_tvalid  = ($urandom_range(3) != 0);
      in_tdest   = 2'($urandom_range(2));
      in_tkeep   = 8'($urandom);
      in_tlast   = (c < 300) ? ($urandom_range(1) == 0) : ($urandom_range(3) == 0);
      out_sel    = 2'($urandom_range(2));
      out_tvalid = (c < 300) ? ($urandom_range(15) == 0) : ($urandom_range(1) == 0);
      out_tready = ($urandom_range(3) != 0);
      out_tlast  = ($urandom_range(1) == 0);
      #1;
      in_tready = ($urandom_range(31) == 0) ? 1'b1 : (in_len_ready && ($urandom_range(4) != 0));
      tick();
      checks++; if (fifo_tvalid !== exp_valid()) begin failures++; $display("FAIL rnd_tvalid c=%0d got=%b exp=%b", c, fifo_tvalid, exp_valid()); end
      checks++; if (fifo_packet_length !== exp_len()) begin failures++; $display("FAIL rnd_len c=%0d got=%h exp=%h", c, fifo_packet_length, exp_len()); end
      checks++; if (len_full !== exp_full()) begin failures++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, len_full, exp_full()); end
      checks++; if ({err_overflow, err_underflow} !== {m_of, m_uf}) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, {err_overflow, err_underflow}, {m_of, m_uf}); end
    end
    in_tvalid = 1'b0; out_tvalid = 1'b0;
  endtask

  initial begin
    in_tvalid = 1'b0; in_tready = 1'b0; in_tkeep = '0; in_tlast = 1'b0; in_tdest = '0;
    out_sel = '0; out_tvalid = 1'b0; out_tready = 1'b0; out_tlast = 1'b0;
    test_reset();
    test_multi_beat();
    test_tdest_switch();
    test_underflow();
    test_fill_overflow();
    test_back_to_back();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
